// File: rtl/drain_bank_writer_pkg.sv
// Shared definitions for the halo drain-buffer bank writer: default geometry,
// per-bank address width derivation, controller state encoding and row type.
package drain_bank_writer_pkg;

    localparam int DEF_LINWDTH = 9;
    localparam int DEF_ADDRLEN = 3;
    localparam int DEF_WORDLEN = 16;
    localparam int DEF_PLDEPTH = 2;

    // Per-bank address width: the line address minus the bank-select bits.
    function automatic int aw_of(input int linwdth, input int addrlen);
        return linwdth - addrlen;
    endfunction

    localparam int DEF_AW = aw_of(DEF_LINWDTH, DEF_ADDRLEN);
    localparam int DEF_N  = 1 << DEF_ADDRLEN;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // One input row: element b is the word destined (before rotation) for bank b.
    typedef logic [DEF_N-1:0][DEF_WORDLEN-1:0] row_t;

endpackage

// File: rtl/drain_bank_writer_bank_rot.sv
// Combinational N-way word rotator: out[b] = in[(b + ramt) mod N].
module drain_bank_writer_bank_rot #(
    parameter  int ADDRLEN = 3,
    parameter  int WORDLEN = 16,
    localparam int N       = 1 << ADDRLEN
) (
    input  logic [N*WORDLEN-1:0] in_row,
    input  logic [ADDRLEN-1:0]   ramt,
    output logic [N*WORDLEN-1:0] out_row
);

    // Select each output word from the input word ramt positions further on.
    always_comb begin
        out_row = '0;
        for (int b = 0; b < N; b++) begin
            out_row[b*WORDLEN +: WORDLEN] = in_row[((b + int'(ramt)) % N)*WORDLEN +: WORDLEN];
        end
    end

endmodule

// File: rtl/drain_bank_writer.sv
// Bank-skewed loader for the dual-port halo drain buffers. Each accepted row is
// rotated by the current line's bank rotation and written to every bank at the
// same address. Address/enable lead the write data by PLDEPTH cycles to match
// the RAM's internal address pipeline.
module drain_bank_writer
    import drain_bank_writer_pkg::*;
#(
    parameter  int LINWDTH = DEF_LINWDTH,
    parameter  int ADDRLEN = DEF_ADDRLEN,
    parameter  int WORDLEN = DEF_WORDLEN,
    parameter  int PLDEPTH = DEF_PLDEPTH,
    localparam int AW      = aw_of(LINWDTH, ADDRLEN),
    localparam int N       = 1 << ADDRLEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        eof,
    input  logic [AW-1:0]        numlines,
    input  logic [ADDRLEN-1:0]   ramstep,
    input  logic [ADDRLEN-1:0]   rot0,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDLEN-1:0] in_data,
    input  logic                 in_last,
    output logic [N*AW-1:0]      addr_o,
    output logic [N-1:0]         en_o,
    output logic [N-1:0]         wren_o,
    output logic [N*WORDLEN-1:0] din_o,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int NW = N * WORDLEN;
    localparam int CW = $clog2(PLDEPTH + 1);

    state_t             state;
    logic [AW-1:0]      eof_r;
    logic [AW-1:0]      numlines_r;
    logic [ADDRLEN-1:0] ramstep_r;
    logic [ADDRLEN-1:0] rot;
    logic [AW-1:0]      offset;
    logic [AW-1:0]      base;
    logic [AW-1:0]      line;
    logic [CW-1:0]      fcnt;

    logic               accept;
    logic               last_off;
    logic               final_beat;
    logic [AW-1:0]      cur_addr;
    logic [NW-1:0]      rot_row;

    logic [NW-1:0]      data_pn [PLDEPTH];
    logic [PLDEPTH-1:0] vld_pn;

    assign accept     = in_valid & in_ready;
    assign last_off   = (offset == eof_r - AW'(1));
    assign final_beat = last_off & (line == numlines_r - AW'(1));
    // Address arithmetic is modulo 2**AW; overflow wraps silently.
    assign cur_addr   = base + offset;

    drain_bank_writer_bank_rot #(
        .ADDRLEN (ADDRLEN),
        .WORDLEN (WORDLEN)
    ) u_bank_rot (
        .in_row  (in_data),
        .ramt    (rot),
        .out_row (rot_row)
    );

    // Job controller: config latch, beat/line counters, registered write port
    // address/enables and handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            eof_r      <= '0;
            numlines_r <= '0;
            ramstep_r  <= '0;
            rot        <= '0;
            offset     <= '0;
            base       <= '0;
            line       <= '0;
            fcnt       <= '0;
            addr_o     <= '0;
            en_o       <= '0;
            wren_o     <= '0;
        end else begin
            // Enables and done are single-cycle unless re-asserted below.
            en_o   <= '0;
            wren_o <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        eof_r      <= eof;
                        numlines_r <= numlines;
                        ramstep_r  <= ramstep;
                        rot        <= rot0;
                        offset     <= '0;
                        base       <= '0;
                        line       <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        if (eof == '0 || numlines == '0) begin
                            // Empty job: nothing to write, report completion next cycle.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        addr_o <= {N{cur_addr}};
                        en_o   <= '1;
                        wren_o <= '1;
                        // The job is count-driven; in_last only feeds the sticky error.
                        if (in_last != final_beat) begin
                            err <= 1'b1;
                        end
                        if (last_off) begin
                            offset <= '0;
                            base   <= base + eof_r;
                            rot    <= rot + ramstep_r;
                            line   <= line + AW'(1);
                        end else begin
                            offset <= offset + AW'(1);
                        end
                        if (final_beat) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            fcnt     <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // Hold until the final row has left the data delay line.
                    if (fcnt == CW'(PLDEPTH)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-data delay line: aligns rotated rows PLDEPTH cycles behind addr_o.
    // Cleared on reset so that rows in flight are dropped rather than written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PLDEPTH; k++) begin
                data_pn[k] <= '0;
            end
            vld_pn <= '0;
            din_o  <= '0;
        end else begin
            // stage p0: rotated row captured alongside the address
            vld_pn[0] <= accept;
            if (accept) begin
                data_pn[0] <= rot_row;
            end
            // stages p1..: plain shift
            for (int k = 1; k < PLDEPTH; k++) begin
                vld_pn[k]  <= vld_pn[k-1];
                data_pn[k] <= data_pn[k-1];
            end
            // output stage: din_o holds between writes
            if (vld_pn[PLDEPTH-1]) begin
                din_o <= data_pn[PLDEPTH-1];
            end
        end
    end

endmodule

// File: tb/tb_drain_bank_writer.sv
// Directed bench for drain_bank_writer with a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_drain_bank_writer;
    import drain_bank_writer_pkg::*;

    localparam int LINWDTH = 9;
    localparam int ADDRLEN = 3;
    localparam int WORDLEN = 16;
    localparam int PLDEPTH = 2;
    localparam int AW      = LINWDTH - ADDRLEN;
    localparam int N       = 1 << ADDRLEN;
    localparam int NW      = N * WORDLEN;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      eof = '0;
    logic [AW-1:0]      numlines = '0;
    logic [ADDRLEN-1:0] ramstep = '0;
    logic [ADDRLEN-1:0] rot0 = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic [NW-1:0]      in_data = '0;
    logic               in_ready;
    logic [N*AW-1:0]    addr_o;
    logic [N-1:0]       en_o;
    logic [N-1:0]       wren_o;
    logic [NW-1:0]      din_o;
    logic               busy;
    logic               done;
    logic               err;

    always #5 clk = ~clk;

    drain_bank_writer #(
        .LINWDTH (LINWDTH),
        .ADDRLEN (ADDRLEN),
        .WORDLEN (WORDLEN),
        .PLDEPTH (PLDEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .eof      (eof),
        .numlines (numlines),
        .ramstep  (ramstep),
        .rot0     (rot0),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .addr_o   (addr_o),
        .en_o     (en_o),
        .wren_o   (wren_o),
        .din_o    (din_o),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Observations shared between the model process and the directed tests.
    int                 cyc = 0;
    int                 wr_count = 0;
    int                 last_acc_c = 0;
    int                 done_c = 0;
    int                 start_c = 0;
    logic [AW-1:0]      obs_addr [int];
    logic [NW-1:0]      obs_din  [int];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t row_pat(input int beat);
        row_t r;
        for (int b = 0; b < N; b++) r[b] = WORDLEN'(100 * beat + b);
        return r;
    endfunction

    function automatic row_t rotate_row(input row_t r, input int rot);
        row_t o;
        for (int b = 0; b < N; b++) o[b] = r[(b + rot) % N];
        return o;
    endfunction

    function automatic logic [WORDLEN-1:0] word_of(input logic [NW-1:0] v, input int b);
        return v[b*WORDLEN +: WORDLEN];
    endfunction

    // Behavioural model and per-cycle comparison. A job is a count of
    // eof*numlines beats; beat k goes to address k mod 2**AW with line rotation
    // rot0 + (k/eof)*ramstep, and done follows the final accept by PLDEPTH+2.
    initial begin : monitor
        int k, total, m_done_at, line, r;
        bit m_busy, m_ready, m_err, start_ok;
        int m_eof, m_step, m_rot0;
        logic [AW-1:0]   hold_addr;
        logic [NW-1:0]   hold_din;
        logic [N*AW-1:0] ea;
        logic            exp_en;
        int              acc_k   [int];
        logic [NW-1:0]   acc_row [int];
        k = 0; total = 0; m_done_at = -10; m_busy = 0; m_ready = 0; m_err = 0;
        m_eof = 1; m_step = 0; m_rot0 = 0; hold_addr = '0; hold_din = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m_busy = 0; m_ready = 0; m_err = 0; m_done_at = -10;
                hold_addr = '0; hold_din = '0;
                acc_k.delete(); acc_row.delete();
            end
            exp_en = acc_k.exists(cyc - 1);
            if (exp_en) hold_addr = AW'(acc_k[cyc-1]);
            if (acc_k.exists(cyc - 1 - PLDEPTH)) hold_din = acc_row[cyc-1-PLDEPTH];
            for (int b = 0; b < N; b++) ea[b*AW +: AW] = hold_addr;
            chk("in_ready", 128'(in_ready), 128'(m_ready));
            chk("busy",     128'(busy),     128'(m_busy));
            chk("done",     128'(done),     128'(cyc == m_done_at));
            chk("err",      128'(err),      128'(m_err));
            chk("en_o",     128'(en_o),     exp_en ? 128'({N{1'b1}}) : 128'(0));
            chk("wren_o",   128'(wren_o),   exp_en ? 128'({N{1'b1}}) : 128'(0));
            chk("addr_o",   128'(addr_o),   128'(ea));
            chk("din_o",    128'(din_o),    128'(hold_din));
            if (exp_en) obs_addr[acc_k[cyc-1]] = addr_o[AW-1:0];
            if (acc_k.exists(cyc - 1 - PLDEPTH)) obs_din[acc_k[cyc-1-PLDEPTH]] = din_o;
            if (|en_o) wr_count++;
            if (done === 1'b1) done_c = cyc;
            if (reset) begin
                start_ok = start && !m_busy;
                if (cyc == m_done_at) m_busy = 0;
                if (start_ok) begin
                    m_eof = int'(eof); m_step = int'(ramstep); m_rot0 = int'(rot0);
                    total = int'(eof) * int'(numlines);
                    k = 0; m_err = 0; m_busy = 1; start_c = cyc;
                    if (total == 0) m_done_at = cyc + 1;
                    else m_ready = 1;
                end else if (m_ready && in_valid) begin
                    line = k / m_eof;
                    r = (m_rot0 + line * m_step) % N;
                    acc_k[cyc] = k;
                    acc_row[cyc] = rotate_row(row_t'(in_data), r);
                    if (in_last != (k == total - 1)) m_err = 1;
                    last_acc_c = cyc;
                    k++;
                    if (k == total) begin
                        m_ready = 0;
                        m_done_at = cyc + PLDEPTH + 2;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int e, input int nl, input int st, input int r0);
        eof = AW'(e); numlines = AW'(nl); ramstep = ADDRLEN'(st); rot0 = ADDRLEN'(r0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int first, input int gap, input int lastpos);
        int w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = NW'(row_pat(first + i));
            in_last  = ((first + i) == lastpos);
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got in_ready=%0b expected 1 within 50 cycles", in_ready);
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_done();
        int w = 0;
        while (done !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) begin
            checks++; errors++;
            $display("FAIL done_timeout: got done=%0b expected 1 within 100 cycles", done);
        end
        tick();
        tick();
    endtask

    task automatic new_test();
        wr_count = 0;
        obs_addr.delete();
        obs_din.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int snap;
        repeat (3) tick();
        chk("rst_busy",  128'(busy),     128'(0));
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_addr",  128'(addr_o),   128'(0));
        chk("rst_din",   128'(din_o),    128'(0));
        chk("rst_err",   128'(err),      128'(0));
        reset = 1'b1;
        tick();

        // Basic job
        new_test();
        start_job(5, 2, 3, 0);
        send_beats(10, 0, 0, 9);
        wait_done();
        chk("basic_writes", 128'(wr_count), 128'(10));
        chk("basic_addr4",  128'(obs_addr[4]), 128'(4));
        chk("basic_addr5",  128'(obs_addr[5]), 128'(5));
        chk("basic_addr9",  128'(obs_addr[9]), 128'(9));
        chk("basic_din5_w0", 128'(word_of(obs_din[5], 0)), 128'(503));
        chk("basic_din5_w5", 128'(word_of(obs_din[5], 5)), 128'(500));
        chk("basic_done_lat", 128'(done_c - last_acc_c), 128'(4));
        chk("basic_err", 128'(err), 128'(0));

        // Throttled input
        new_test();
        start_job(5, 2, 3, 0);
        send_beats(10, 0, 1, 9);
        wait_done();
        chk("thr_writes", 128'(wr_count), 128'(10));
        chk("thr_addr9",  128'(obs_addr[9]), 128'(9));
        chk("thr_din5_w0", 128'(word_of(obs_din[5], 0)), 128'(503));
        chk("thr_done_lat", 128'(done_c - last_acc_c), 128'(4));

        // Rotation wraps modulo N: 6, 1, 4
        new_test();
        start_job(2, 3, 3, 6);
        send_beats(6, 0, 0, 5);
        wait_done();
        chk("rot_l0_w0", 128'(word_of(obs_din[0], 0)), 128'(6));
        chk("rot_l1_w0", 128'(word_of(obs_din[2], 0)), 128'(201));
        chk("rot_l2_w0", 128'(word_of(obs_din[4], 0)), 128'(404));
        chk("rot_l2_w7", 128'(word_of(obs_din[4], 7)), 128'(403));

        // in_last on beat 2 of 10 and missing on final beat
        new_test();
        start_job(5, 2, 3, 0);
        send_beats(10, 0, 0, 2);
        wait_done();
        chk("last_err_set", 128'(err), 128'(1));
        chk("last_writes",  128'(wr_count), 128'(10));
        new_test();
        start_job(1, 1, 0, 0);
        chk("last_err_clr", 128'(err), 128'(0));
        send_beats(1, 0, 0, 0);
        wait_done();
        chk("last_err_ok", 128'(err), 128'(0));

        // Degenerate jobs
        new_test();
        start_job(3, 0, 0, 0);
        wait_done();
        chk("degen_nl_lat", 128'(done_c - start_c), 128'(1));
        chk("degen_nl_wr",  128'(wr_count), 128'(0));
        new_test();
        start_job(0, 4, 0, 0);
        wait_done();
        chk("degen_eof_lat", 128'(done_c - start_c), 128'(1));
        chk("degen_eof_wr",  128'(wr_count), 128'(0));

        // start during RUN is ignored
        new_test();
        start_job(4, 2, 1, 0);
        send_beats(3, 0, 0, 7);
        start_job(1, 1, 5, 5);
        send_beats(5, 3, 0, 7);
        wait_done();
        chk("ign_writes", 128'(wr_count), 128'(8));
        chk("ign_addr7",  128'(obs_addr[7]), 128'(7));
        chk("ign_din4_w0", 128'(word_of(obs_din[4], 0)), 128'(401));
        chk("ign_err", 128'(err), 128'(0));

        // Address wrap past 2**AW-1
        new_test();
        start_job(20, 4, 0, 0);
        send_beats(80, 0, 0, 79);
        wait_done();
        chk("wrap_addr63", 128'(obs_addr[63]), 128'(63));
        chk("wrap_addr64", 128'(obs_addr[64]), 128'(0));
        chk("wrap_addr79", 128'(obs_addr[79]), 128'(15));
        chk("wrap_err", 128'(err), 128'(0));

        // Reset mid-job after beat 3
        new_test();
        start_job(5, 2, 3, 0);
        send_beats(4, 0, 0, 9);
        reset = 1'b0;
        #1;
        chk("mid_rst_en",    128'(en_o),     128'(0));
        chk("mid_rst_addr",  128'(addr_o),   128'(0));
        chk("mid_rst_din",   128'(din_o),    128'(0));
        chk("mid_rst_busy",  128'(busy),     128'(0));
        chk("mid_rst_ready", 128'(in_ready), 128'(0));
        snap = wr_count;
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("mid_rst_nowr", 128'(wr_count), 128'(snap));
        chk("mid_rst_cnt",  128'(snap), 128'(3));
        new_test();
        start_job(5, 2, 3, 0);
        send_beats(10, 0, 0, 9);
        wait_done();
        chk("post_rst_writes", 128'(wr_count), 128'(10));
        chk("post_rst_din5_w0", 128'(word_of(obs_din[5], 0)), 128'(503));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drain_bank_writer.md
# drain_bank_writer

Bank-skewed loader that fills the dual-port halo drain buffers ahead of halo resolution. It accepts rows of 2**ADDRLEN words over a valid/ready stream. Each row is rotated by a per-line bank rotation and written to all banks at one address per bank. Outputs drive the RAM write port directly and honour the RAM's PLDEPTH-cycle address/enable pipeline.

## Interface
- LINWDTH, 9, total line address width; per-bank address width AW = LINWDTH-ADDRLEN
- ADDRLEN, 3, log2 of bank count; N = 2**ADDRLEN banks
- WORDLEN, 16, data word width
- PLDEPTH, 2, RAM write-pipeline depth (addr/en/wren lead data by this many cycles)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; latches config, begins job
- eof  in  AW  beats per line (line length in per-bank words)
- numlines  in  AW  lines per job
- ramstep  in  ADDRLEN  rotation increment applied at each line wrap
- rot0  in  ADDRLEN  rotation for line 0
- in_valid  in  1  row valid
- in_ready  out  1  row accepted when in_valid & in_ready
- in_data  in  N×WORDLEN  row, element b = word b
- in_last  in  1  producer marks final row of job
- addr_o  out  N×AW  per-bank write address
- en_o, wren_o  out  N  per-bank enable / write enable
- din_o  out  N×WORDLEN  per-bank write data, PLDEPTH cycles behind addr_o
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky in_last mismatch, cleared by start

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, latch eof, numlines, ramstep, rot0; clear offset, base, line, err.
  - eof==0 or numlines==0: go to DONE (no writes).
  - Otherwise: go to RUN.
- start while not IDLE is ignored.
- RUN: in_ready=1. Per accepted beat:
  - Registered outputs: addr_o[b] = (base+offset) mod 2**AW; en_o = wren_o = all ones.
  - Rotated row din_o[b] = in_data[(b+rot) mod N] enters a PLDEPTH-stage delay line.
  - Counters: offset+1. When offset==eof-1: offset←0, base←base+eof (mod 2**AW), rot←rot+ramstep (mod N), line+1.
  - Final beat (line==numlines-1 and offset==eof-1): go to FLUSH.
- in_last check: in_last on a non-final beat, or in_last absent on the final beat, sets err. Counting is unaffected; the job is count-driven only.
- FLUSH: in_ready=0, en_o/wren_o=0. Wait PLDEPTH cycles until the last din_o has been presented, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = state != IDLE.
- Cycles with no accepted beat: en_o/wren_o=0, addr_o holds.

## Timing
- Reset values: in_ready=0, addr_o=0, en_o=0, wren_o=0, din_o=0, busy=0, done=0, err=0; state IDLE.
- Beat accepted at cycle T:
  - addr_o/en_o/wren_o valid at T+1.
  - din_o valid at T+1+PLDEPTH.
- Back-to-back beats are sustained at 1 row per cycle; in_valid gaps insert idle write cycles.
- done asserts at (final-beat cycle)+PLDEPTH+2; busy falls the cycle after done.
- Degenerate job: start at T gives done at T+1 and busy high for T+1 only.
- Reset mid-job: immediate return to IDLE with all outputs at reset values; in-flight delay-line data is dropped.
- Address wrap: base+offset above 2**AW-1 wraps silently. No error is raised.

## Structure
- Shared package holds:
  - AW localparam derivation.
  - State enum {IDLE, RUN, FLUSH, DONE}.
  - Row typedef logic [N-1:0][WORDLEN-1:0].
- Sub-module bank_rot: combinational N-way word rotator, out[b] = in[(b+ramt) mod N]. It is instantiated once on the input row.
- The din delay line is a PLDEPTH-deep register array inside the top module.

## Test plan
- Basic job: eof=5, numlines=2, ramstep=3, rot0=0, in_data[b]=100·beat+b, continuous valid. Expect:
  - 10 writes.
  - Line-0 beats: addr 0..4.
  - Line-1 beats: addr 5..9.
  - Line-1 beat 0: din_o[0]=503, din_o[5]=500.
  - done at final-accept+4.
- Throttling: same job with in_valid every other cycle. Expect the same addresses and data, en_o low on gap cycles, and done 4 cycles after the last accept.
- Rotation wrap: N=8, rot0=6, ramstep=3, numlines=3. Expect line rotations 6, 1, 4.
- in_last errors:
  - in_last on beat 2 of a 10-beat job: err=1, all 10 writes still occur, done pulses.
  - Next start: err clears.
- Degenerate and ignored starts:
  - numlines=0: done one cycle after start, zero writes.
  - start during RUN: ignored.
- Reset mid-job: reset low after beat 3. Expect all outputs 0 immediately, no further writes, and a fresh start running normally.
